elevator_call_scheduler: RTL and testbench
==========================================

// Module: elevator_call_scheduler
// PURPOSE
//  Sits between the per-floor debounce outputs and the motor movement controller. Latches floor
//  call pulses into a pending-call register and serves calls in SCAN order (keep direction while
//  calls remain ahead). Drives the target floor to the movement controller and times a door dwell
//  at each served floor. Car position arrives as a decoded floor index and a settled flag.
// PARAMETERS
//  NUM_FLOORS    5           number of floors/call keys (2..8)
//  FLOOR_W       3           width of floor index
//  DWELL_CYCLES  12_000_000  door-open dwell in clk cycles (1 s at 12 MHz)
//  DWELL_W       24          dwell counter width; must hold DWELL_CYCLES
// PORTS
//  clk          in   1           system clock
//  rst          in   1           asynchronous, active-high reset
//  key_pulse    in   NUM_FLOORS  one-cycle debounced call pulses, bit k = floor k (0-based)
//  cur_floor    in   FLOOR_W     nearest floor decoded from the distance sensor
//  at_floor     in   1           car settled within the stop band of cur_floor
//  door_hold    in   1           held high: dwell counter held at 0 (door kept open)
//  target_floor out  FLOOR_W     floor index to the movement controller
//  moving       out  1           state is MOVE_UP or MOVE_DOWN
//  dir_up       out  1           last/current travel direction, 1 = up
//  door_open    out  1           state is DWELL
//  pending      out  NUM_FLOORS  registered outstanding calls
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, pending=0, target_floor=0, dir_up=1, door_open=0,
//   moving=0, dwell counter=0. Reset mid-move drops every call; target becomes 0.
//  pending: bit k sets on the clock edge after key_pulse[k]. Bit cur_floor clears on DWELL entry.
//   Set and clear on the same edge for the same bit: clear wins. A pulse for cur_floor during DWELL
//   does not set pending; it restarts the dwell counter.
//  Search (combinational on registered pending): above = lowest pending > cur_floor; below = highest
//   pending < cur_floor; any_above, any_below.
//  Latency: key pulse at edge N -> pending at N+1 -> state/target at N+2 (all outputs registered).
//  FSM:
//   IDLE: target=cur_floor. pending[cur_floor]&&at_floor -> DWELL. Else calls on both sides: go in
//    dir_up direction. Else any_above -> MOVE_UP (target=above, dir_up=1). Else any_below -> MOVE_DOWN
//    (target=below, dir_up=0). Else stay.
//   MOVE_UP: target re-evaluated each cycle to `above` (a new call between car and target is taken).
//    at_floor && cur_floor==target -> DWELL. A call at or below cur_floor stays pending.
//   MOVE_DOWN: mirror of MOVE_UP using `below`.
//   DWELL: door_open=1. Counter counts 0..DWELL_CYCLES-1. door_hold or a same-floor pulse resets it
//    to 0. On expiry: dir_up&&any_above -> MOVE_UP. !dir_up&&any_below -> MOVE_DOWN. Else the other
//    side if it has calls (dir_up flips). Else IDLE. Counter returns to 0 on exit.
//  cur_floor >= NUM_FLOORS: at_floor is ignored, no arrival or search, and the state holds.
//  Key pulses above NUM_FLOORS-1 do not exist (port width). Multiple simultaneous pulses all latch.
// STRUCTURE
//  elevator_defs.vh: NUM_FLOORS, FLOOR_W, state localparams IDLE=2'd0, MOVE_UP=2'd1,
//   MOVE_DOWN=2'd2, DWELL=2'd3. Shared with the movement controller.
//  Sub-module call_search: combinational (pending, cur_floor) -> above, below, any_above, any_below.
//  Top: pending register, 2-bit state register, dwell counter, registered outputs.
// TESTING (bench: NUM_FLOORS=5, DWELL_CYCLES=4)
//  1 Reset mid-MOVE_UP with pending=5'b10100 -> pending=0, target=0, moving=0, dir_up=1.
//  2 Idle at floor 0, pulse key 3 -> pending[3] at +1 cycle, MOVE_UP with target=3 at +2. Hold at
//    cur=3 with at_floor -> DWELL, pending=0, door_open for 4 cycles, then IDLE.
//  3 MOVE_UP to 4 with cur=1, pulse key 2 -> target switches to 2. After dwell, continue to 4.
//  4 At floor 2 in DWELL, dir_up=1, pending={0,4} -> serve 4 first, then MOVE_DOWN to 0, dir_up=0.
//  5 DWELL at floor 1: pulse key 1 at count 3 -> counter restarts, pending[1] stays 0. door_hold
//    high 10 cycles -> door_open stays 1 throughout.
//  6 cur_floor=7 with at_floor=1 in MOVE_DOWN -> no arrival, state holds. Key pulses 0 and 4 on the
//    same cycle -> pending=5'b10001.

Source files
------------

// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types and default sizing for the elevator call scheduler and its search logic.
package elevator_call_scheduler_pkg;

  localparam int unsigned DEF_NUM_FLOORS = 5;
  localparam int unsigned DEF_FLOOR_W    = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DWELL     = 2'd3
  } state_e;

endpackage

// File: rtl/elevator_call_scheduler_call_search.sv
// Combinational nearest-call search: lowest pending floor above the car, highest pending below.
module call_search
  import elevator_call_scheduler_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int unsigned FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    cur_floor_i,
  output logic [FLOOR_W-1:0]    above_o,
  output logic [FLOOR_W-1:0]    below_o,
  output logic                  any_above_o,
  output logic                  any_below_o
);

  always_comb begin
    above_o     = '0;
    below_o     = '0;
    any_above_o = 1'b0;
    any_below_o = 1'b0;
    // Scan top-down so the last hit is the lowest floor above the car.
    for (int unsigned k = NUM_FLOORS; k > 0; k--) begin
      if (pending_i[k-1] && (FLOOR_W'(k-1) > cur_floor_i)) begin
        above_o     = FLOOR_W'(k-1);
        any_above_o = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_FLOORS; k++) begin
      if (pending_i[k] && (FLOOR_W'(k) < cur_floor_i)) begin
        below_o     = FLOOR_W'(k);
        any_below_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN-order call scheduler: latches floor calls, picks the next target and times the door dwell.
module elevator_call_scheduler
  import elevator_call_scheduler_pkg::*;
#(
  parameter int unsigned NUM_FLOORS   = DEF_NUM_FLOORS,
  parameter int unsigned FLOOR_W      = DEF_FLOOR_W,
  parameter int unsigned DWELL_CYCLES = 12_000_000,
  parameter int unsigned DWELL_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] key_pulse,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  at_floor,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned        FW1        = FLOOR_W + 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d, cur_mask;
  logic [FLOOR_W-1:0]      target_q, target_d, above, below;
  logic [DWELL_W-1:0]      dwell_q, dwell_d;
  logic                    dir_up_q, dir_up_d, moving_q, moving_d, door_q, door_d;
  logic                    any_above, any_below, floor_ok, call_here, restart;

  call_search #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_search (
    .pending_i   (pending_q),
    .cur_floor_i (cur_floor),
    .above_o     (above),
    .below_o     (below),
    .any_above_o (any_above),
    .any_below_o (any_below)
  );

  assign floor_ok  = {1'b0, cur_floor} < FW1'(NUM_FLOORS);
  assign cur_mask  = floor_ok ? (NUM_FLOORS'(1) << cur_floor) : '0;
  assign call_here = (pending_q & cur_mask) != '0;
  assign restart   = door_hold || ((key_pulse & cur_mask) != '0);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    dir_up_d  = dir_up_q;
    dwell_d   = dwell_q;
    // A same-floor call while the door is open only extends the dwell.
    pending_d = pending_q | ((state_q == DWELL) ? (key_pulse & ~cur_mask) : key_pulse);
    if (floor_ok) begin
      case (state_q)
        IDLE: begin
          target_d = cur_floor;
          if (call_here && at_floor) begin
            state_d = DWELL;
            dwell_d = '0;
          end else if (any_above && (dir_up_q || !any_below)) begin
            state_d  = MOVE_UP;
            target_d = above;
            dir_up_d = 1'b1;
          end else if (any_below) begin
            state_d  = MOVE_DOWN;
            target_d = below;
            dir_up_d = 1'b0;
          end
        end
        // Once the car reads as the target floor, hold the target until it settles.
        MOVE_UP: begin
          if (at_floor && (cur_floor == target_q)) begin
            state_d = DWELL;
            dwell_d = '0;
          end else if ((cur_floor != target_q) && any_above) begin
            target_d = above;
          end
        end
        MOVE_DOWN: begin
          if (at_floor && (cur_floor == target_q)) begin
            state_d = DWELL;
            dwell_d = '0;
          end else if ((cur_floor != target_q) && any_below) begin
            target_d = below;
          end
        end
        DWELL: begin
          if (restart) begin
            dwell_d = '0;
          end else if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (dir_up_q && any_above) begin
              state_d  = MOVE_UP;
              target_d = above;
            end else if (!dir_up_q && any_below) begin
              state_d  = MOVE_DOWN;
              target_d = below;
            end else if (any_above) begin
              state_d  = MOVE_UP;
              target_d = above;
              dir_up_d = 1'b1;
            end else if (any_below) begin
              state_d  = MOVE_DOWN;
              target_d = below;
              dir_up_d = 1'b0;
            end else begin
              state_d  = IDLE;
              target_d = cur_floor;
            end
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
      endcase
    end
    if ((state_d == DWELL) && (state_q != DWELL)) begin
      pending_d = pending_d & ~cur_mask;
    end
    moving_d = (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
    door_d   = (state_d == DWELL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      target_q  <= '0;
      dwell_q   <= '0;
      dir_up_q  <= 1'b1;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      dwell_q   <= dwell_d;
      dir_up_q  <= dir_up_d;
      moving_q  <= moving_d;
      door_q    <= door_d;
    end
  end

  assign target_floor = target_q;
  assign moving       = moving_q;
  assign dir_up       = dir_up_q;
  assign door_open    = door_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scenario bench for elevator_call_scheduler: step tables feed a scoreboard of expected outputs.
module tb_elevator_call_scheduler;

  localparam int unsigned NF = 5;
  localparam int unsigned FW = 3;
  localparam int unsigned DC = 4;
  localparam int unsigned DW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] key_pulse;
  logic [FW-1:0] cur_floor;
  logic          at_floor, door_hold;
  logic [FW-1:0] target_floor;
  logic          moving, dir_up, door_open;
  logic [NF-1:0] pending;
  logic [10:0]   obs;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NF-1:0] key;
    logic [FW-1:0] cur;
    logic          at;
    logic          hold;
    logic [10:0]   exp;
  } step_t;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } exp_t;

  step_t steps[$];
  exp_t  sb[$];

  elevator_call_scheduler #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .DWELL_CYCLES (DC),
    .DWELL_W      (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_pulse    (key_pulse),
    .cur_floor    (cur_floor),
    .at_floor     (at_floor),
    .door_hold    (door_hold),
    .target_floor (target_floor),
    .moving       (moving),
    .dir_up       (dir_up),
    .door_open    (door_open),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  assign obs = {target_floor, moving, dir_up, door_open, pending};

  // Expected output word: {target, moving, dir_up, door_open, pending}.
  function automatic logic [10:0] ex(int t, bit mv, bit d, bit door, logic [NF-1:0] p);
    return {FW'(t), mv, d, door, p};
  endfunction

  function automatic step_t st(logic [NF-1:0] key, int cur, bit at, bit hold, logic [10:0] e);
    step_t s;
    s.key = key; s.cur = FW'(cur); s.at = at; s.hold = hold; s.exp = e;
    return s;
  endfunction

  task automatic do_reset();
    key_pulse = '0; cur_floor = '0; at_floor = 1'b1; door_hold = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t  e;
    step_t s;
    key_pulse = '0; cur_floor = '0; at_floor = 1'b1; door_hold = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    sb.push_back('{"reset_initial", ex(0, 0, 1, 0, 5'b00000)});
    #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e.exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", e.tag, obs, e.exp);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    steps.push_back(st(5'b10100, 0, 1, 0, ex(0, 0, 1, 0, 5'b10100)));
    steps.push_back(st(5'b00000, 0, 1, 0, ex(2, 1, 1, 0, 5'b10100)));
    for (int i = 0; steps.size() > 0; i++) begin
      s = steps.pop_front();
      key_pulse = s.key; cur_floor = s.cur; at_floor = s.at; door_hold = s.hold;
      sb.push_back('{$sformatf("reset_setup_%0d", i), s.exp});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", e.tag, obs, e.exp);
      end
    end
    key_pulse = '0;
    rst = 1'b1;
    sb.push_back('{"reset_mid_move", ex(0, 0, 1, 0, 5'b00000)});
    #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e.exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", e.tag, obs, e.exp);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_call();
    exp_t  e;
    step_t s;
    do_reset();
    steps.push_back(st(5'b01000, 0, 1, 0, ex(0, 0, 1, 0, 5'b01000)));
    steps.push_back(st(5'b00000, 0, 1, 0, ex(3, 1, 1, 0, 5'b01000)));
    for (int i = 0; i < 4; i++) steps.push_back(st(5'b00000, 3, 1, 0, ex(3, 0, 1, 1, 5'b00000)));
    steps.push_back(st(5'b00000, 3, 1, 0, ex(3, 0, 1, 0, 5'b00000)));
    for (int i = 0; steps.size() > 0; i++) begin
      s = steps.pop_front();
      key_pulse = s.key; cur_floor = s.cur; at_floor = s.at; door_hold = s.hold;
      sb.push_back('{$sformatf("single_call_%0d", i), s.exp});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic test_intermediate_call();
    exp_t  e;
    step_t s;
    do_reset();
    steps.push_back(st(5'b10000, 0, 1, 0, ex(0, 0, 1, 0, 5'b10000)));
    steps.push_back(st(5'b00000, 0, 1, 0, ex(4, 1, 1, 0, 5'b10000)));
    steps.push_back(st(5'b00000, 1, 0, 0, ex(4, 1, 1, 0, 5'b10000)));
    steps.push_back(st(5'b00100, 1, 0, 0, ex(4, 1, 1, 0, 5'b10100)));
    steps.push_back(st(5'b00000, 1, 0, 0, ex(2, 1, 1, 0, 5'b10100)));
    for (int i = 0; i < 4; i++) steps.push_back(st(5'b00000, 2, 1, 0, ex(2, 0, 1, 1, 5'b10000)));
    steps.push_back(st(5'b00000, 2, 1, 0, ex(4, 1, 1, 0, 5'b10000)));
    steps.push_back(st(5'b00000, 4, 1, 0, ex(4, 0, 1, 1, 5'b00000)));
    for (int i = 0; steps.size() > 0; i++) begin
      s = steps.pop_front();
      key_pulse = s.key; cur_floor = s.cur; at_floor = s.at; door_hold = s.hold;
      sb.push_back('{$sformatf("intermediate_%0d", i), s.exp});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic test_scan_order();
    exp_t  e;
    step_t s;
    do_reset();
    steps.push_back(st(5'b00100, 0, 1, 0, ex(0, 0, 1, 0, 5'b00100)));
    steps.push_back(st(5'b00000, 0, 1, 0, ex(2, 1, 1, 0, 5'b00100)));
    steps.push_back(st(5'b00000, 2, 1, 0, ex(2, 0, 1, 1, 5'b00000)));
    steps.push_back(st(5'b10001, 2, 1, 0, ex(2, 0, 1, 1, 5'b10001)));
    for (int i = 0; i < 2; i++) steps.push_back(st(5'b00000, 2, 1, 0, ex(2, 0, 1, 1, 5'b10001)));
    steps.push_back(st(5'b00000, 2, 1, 0, ex(4, 1, 1, 0, 5'b10001)));
    for (int i = 0; i < 4; i++) steps.push_back(st(5'b00000, 4, 1, 0, ex(4, 0, 1, 1, 5'b00001)));
    steps.push_back(st(5'b00000, 4, 1, 0, ex(0, 1, 0, 0, 5'b00001)));
    steps.push_back(st(5'b00000, 0, 1, 0, ex(0, 0, 0, 1, 5'b00000)));
    for (int i = 0; steps.size() > 0; i++) begin
      s = steps.pop_front();
      key_pulse = s.key; cur_floor = s.cur; at_floor = s.at; door_hold = s.hold;
      sb.push_back('{$sformatf("scan_order_%0d", i), s.exp});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic test_dwell_extend();
    exp_t  e;
    step_t s;
    do_reset();
    steps.push_back(st(5'b00010, 0, 1, 0, ex(0, 0, 1, 0, 5'b00010)));
    steps.push_back(st(5'b00000, 0, 1, 0, ex(1, 1, 1, 0, 5'b00010)));
    for (int i = 0; i < 4; i++) steps.push_back(st(5'b00000, 1, 1, 0, ex(1, 0, 1, 1, 5'b00000)));
    steps.push_back(st(5'b00010, 1, 1, 0, ex(1, 0, 1, 1, 5'b00000)));
    for (int i = 0; i < 3; i++) steps.push_back(st(5'b00000, 1, 1, 0, ex(1, 0, 1, 1, 5'b00000)));
    for (int i = 0; i < 10; i++) steps.push_back(st(5'b00000, 1, 1, 1, ex(1, 0, 1, 1, 5'b00000)));
    for (int i = 0; i < 3; i++) steps.push_back(st(5'b00000, 1, 1, 0, ex(1, 0, 1, 1, 5'b00000)));
    steps.push_back(st(5'b00000, 1, 1, 0, ex(1, 0, 1, 0, 5'b00000)));
    for (int i = 0; steps.size() > 0; i++) begin
      s = steps.pop_front();
      key_pulse = s.key; cur_floor = s.cur; at_floor = s.at; door_hold = s.hold;
      sb.push_back('{$sformatf("dwell_extend_%0d", i), s.exp});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic test_invalid_floor();
    exp_t  e;
    step_t s;
    do_reset();
    steps.push_back(st(5'b00010, 4, 1, 0, ex(4, 0, 1, 0, 5'b00010)));
    steps.push_back(st(5'b00000, 4, 1, 0, ex(1, 1, 0, 0, 5'b00010)));
    for (int i = 0; i < 2; i++) steps.push_back(st(5'b00000, 7, 1, 0, ex(1, 1, 0, 0, 5'b00010)));
    steps.push_back(st(5'b00000, 1, 1, 0, ex(1, 0, 0, 1, 5'b00000)));
    for (int i = 0; steps.size() > 0; i++) begin
      s = steps.pop_front();
      key_pulse = s.key; cur_floor = s.cur; at_floor = s.at; door_hold = s.hold;
      sb.push_back('{$sformatf("invalid_floor_%0d", i), s.exp});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic test_multi_pulse();
    exp_t  e;
    step_t s;
    do_reset();
    steps.push_back(st(5'b10001, 7, 1, 0, ex(0, 0, 1, 0, 5'b10001)));
    steps.push_back(st(5'b00000, 7, 1, 0, ex(0, 0, 1, 0, 5'b10001)));
    steps.push_back(st(5'b00000, 2, 1, 0, ex(4, 1, 1, 0, 5'b10001)));
    for (int i = 0; steps.size() > 0; i++) begin
      s = steps.pop_front();
      key_pulse = s.key; cur_floor = s.cur; at_floor = s.at; door_hold = s.hold;
      sb.push_back('{$sformatf("multi_pulse_%0d", i), s.exp});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_intermediate_call();
    test_scan_order();
    test_dwell_extend();
    test_invalid_floor();
    test_multi_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
